// File: rtl/dmem_responder_if.sv
// Request/response bus between the core mem stage (master) and dmem_responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM responder with programmable response latency.
// Optional debug MMIO register enabled by defining DMEM_MMIO_EN.
module dmem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] MMIO_ADDR = 32'hFFFF_0000
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    output logic [31:0]      mmio_out
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    logic        req_hs;
    logic        commit;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_wstrb;
    logic [AW-1:0] idx;
    logic        hit_mmio;
    logic        in_range;
    logic        strb_ok;
    logic        a_err;
    logic [31:0] rd_word;

    assign req_hs = bus.req_valid & bus.req_ready;
    // With LATENCY==1 the access happens on the accepting edge itself, so it sees the live request.
    assign commit = (state == IDLE && req_hs && LATENCY == 1) || (state == BUSY && cnt == 4'd1);

    always_comb begin
        if (state == IDLE) begin
            a_we    = bus.req_we;
            a_addr  = bus.req_addr;
            a_wdata = bus.req_wdata;
            a_wstrb = bus.req_wstrb;
        end else begin
            a_we    = we_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
            a_wstrb = wstrb_q;
        end
    end

    always_comb begin
        idx      = a_addr[AW+1:2];
        hit_mmio = MMIO_EN && (a_addr == MMIO_ADDR);
        in_range = {1'b0, a_addr} < LIMIT;
        case (a_wstrb)
            4'b1111:                            strb_ok = (a_addr[1:0] == 2'd0);
            4'b0011, 4'b1100:                   strb_ok = (a_addr[0] == 1'b0);
            4'b0001, 4'b0010, 4'b0100, 4'b1000: strb_ok = 1'b1;
            default:                            strb_ok = 1'b0;
        endcase
        a_err = !(in_range || hit_mmio) || (a_we ? !strb_ok : (a_addr[1:0] != 2'd0));
`ifdef DMEM_MMIO_EN
        rd_word = hit_mmio ? mmio_out : mem[idx];
`else
        rd_word = mem[idx];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_hs) state_next = (LATENCY == 1) ? RESP : BUSY;
            BUSY: if (cnt == 4'd1) state_next = RESP;
            RESP: if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (req_hs) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                wstrb_q <= bus.req_wstrb;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                err_q   <= a_err;
                rdata_q <= (a_err || a_we) ? '0 : rd_word;
            end
        end
    end

    // RAM is deliberately outside the reset domain; reset only suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && a_we && !a_err && !hit_mmio) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (a_wstrb[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

`ifdef DMEM_MMIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mmio_out <= '0;
        end else if (commit && a_we && !a_err && hit_mmio) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (a_wstrb[i]) mmio_out[8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end
`else
    assign mmio_out = '0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (honours DMEM_MMIO_EN if defined).
module tb_dmem_responder;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mmio_out;
    int          checks = 0;
    int          errors = 0;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY),
        .MMIO_ADDR (32'hFFFF_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mmio_out (mmio_out)
    );

    always #5 clk = ~clk;

    // Issues one request with resp_ready high; called #1 after a rising edge, returns likewise.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                        output int lat);
        int n;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_wstrb  = strb;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = 32'h0000_0040;
        bus.req_wdata = 32'hA5A5_A5A5;
        bus.req_wstrb = 4'hF;
        lat = 1;
        while (!bus.resp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_wstrb = '0; bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: req_ready=%b resp_valid=%b expected 1 0", bus.req_ready, bus.resp_valid);
        end
        checks++;
        if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0 || mmio_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h err=%b mmio=%h expected 0 0 0", bus.resp_rdata, bus.resp_err, mmio_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL store_resp: rdata=%h err=%b expected 00000000 0", rd, er);
        end
        checks++;
        if (lat != int'(LATENCY)) begin
            errors++; $display("FAIL store_latency: got %0d expected %0d", lat, LATENCY);
        end
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != int'(LATENCY)) begin
            errors++; $display("FAIL load_word: rdata=%h err=%b lat=%0d expected deadbeef 0 %0d", rd, er, lat, LATENCY);
        end
    endtask

    task automatic test_byte_store;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h10, 32'h1122_3344, 4'hF, rd, er, lat);
        xact(1'b1, 32'h11, 32'h0000_AA00, 4'b0010, rd, er, lat);
        checks++;
        if (er !== 1'b0) begin
            errors++; $display("FAIL byte_store_err: err=%b expected 0", er);
        end
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h1122_AA44 || er !== 1'b0) begin
            errors++; $display("FAIL byte_merge: rdata=%h err=%b expected 1122aa44 0", rd, er);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL misaligned_load: rdata=%h err=%b expected 00000000 1", rd, er);
        end
        xact(1'b0, DEPTH * 4, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL range_load: rdata=%h err=%b expected 00000000 1", rd, er);
        end
        xact(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0110, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL bad_strb: rdata=%h err=%b expected 00000000 1", rd, er);
        end
        xact(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin
            errors++; $display("FAIL zero_strb: err=%b expected 1", er);
        end
        xact(1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin
            errors++; $display("FAIL misaligned_word_store: err=%b expected 1", er);
        end
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h1122_AA44 || er !== 1'b0) begin
            errors++; $display("FAIL err_no_write: rdata=%h err=%b expected 1122aa44 0", rd, er);
        end
    endtask

    task automatic test_boundary;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, DEPTH * 4 - 4, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        xact(1'b0, DEPTH * 4 - 4, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            errors++; $display("FAIL last_word: rdata=%h err=%b expected cafef00d 0", rd, er);
        end
    endtask

    task automatic test_stall;
        int n;
        bus.resp_ready = 1'b0;
        bus.req_we = 1'b0; bus.req_addr = 32'h10; bus.req_wstrb = 4'h0; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h1122_AA44 || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b rdata=%h req_ready=%b expected 1 1122aa44 0",
                         i, bus.resp_valid, bus.resp_rdata, bus.req_ready);
            end
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release: valid=%b req_ready=%b expected 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_back_to_back;
        int hs [2];
        int nhs;
        int n;
        nhs = 0;
        bus.resp_ready = 1'b1;
        bus.req_we = 1'b0; bus.req_addr = 32'h10; bus.req_wstrb = 4'h0; bus.req_valid = 1'b1;
        for (int k = 0; k < 30 && nhs < 2; k++) begin
            if (bus.req_ready) begin
                hs[nhs] = k;
                nhs++;
            end
            if (nhs < 2) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++;
        if (nhs != 2 || hs[1] - hs[0] != int'(LATENCY) + 1) begin
            errors++; $display("FAIL b2b_spacing: handshakes=%0d spacing=%0d expected 2 %0d",
                               nhs, hs[1] - hs[0], LATENCY + 1);
        end
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_busy;
        logic [31:0] rd; logic er; int lat; bit seen;
        xact(1'b1, 32'h20, 32'h0000_0005, 4'hF, rd, er, lat);
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'hFFFF_FFFF;
        bus.req_wstrb = 4'hF; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
            bus.resp_err !== 1'b0 || mmio_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: req_ready=%b valid=%b rdata=%h err=%b mmio=%h expected 1 0 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, mmio_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.resp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL stale_resp: resp_valid seen=1 expected 0");
        end
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_0005 || er !== 1'b0) begin
            errors++; $display("FAIL aborted_store: rdata=%h err=%b expected 00000005 0", rd, er);
        end
    endtask

    task automatic test_mmio;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'hFFFF_0000, 32'h0000_002A, 4'hF, rd, er, lat);
`ifdef DMEM_MMIO_EN
        checks++;
        if (er !== 1'b0 || mmio_out !== 32'h0000_002A) begin
            errors++; $display("FAIL mmio_store: err=%b mmio=%h expected 0 0000002a", er, mmio_out);
        end
        xact(1'b0, 32'hFFFF_0000, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_002A || er !== 1'b0) begin
            errors++; $display("FAIL mmio_load: rdata=%h err=%b expected 0000002a 0", rd, er);
        end
`else
        checks++;
        if (er !== 1'b1 || mmio_out !== 32'h0) begin
            errors++; $display("FAIL mmio_off_store: err=%b mmio=%h expected 1 00000000", er, mmio_out);
        end
        xact(1'b0, 32'hFFFF_0000, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            errors++; $display("FAIL mmio_off_load: rdata=%h err=%b expected 00000000 1", rd, er);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_store();
        test_errors();
        test_boundary();
        test_stall();
        test_back_to_back();
        test_reset_mid_busy();
        test_mmio();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store (mem-stage) requests; the core acts as initiator, this block as target.
- Holds a word-addressed data RAM and accepts one request at a time over a valid/ready handshake.
- Returns read data or a write acknowledge after a programmable latency, with an error flag for illegal accesses.
- Sits between the core's mem stage and on-chip block RAM; also exposes a debug MMIO register.

Parameters:
- DEPTH, 1024, number of 32-bit words in RAM (power of two).
- LATENCY, 2, cycles from request acceptance to resp_valid (1..15).
- MMIO_ADDR, 32'hFFFF_0000, byte address of the debug output register.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, already lane-aligned.
- req_wstrb  in  4  byte enables for stores; ignored for loads.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  access was illegal.
- mmio_out  out  32  debug register value.

Behaviour:
- Reset (asynchronous, any time):
  - State goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mmio_out=0.
  - RAM contents are not cleared.
  - Any in-flight request is dropped with no response.
- State IDLE:
  - req_ready=1.
  - A handshake (req_valid & req_ready) latches we/addr/wdata/wstrb, loads the latency counter with LATENCY-1, and moves to BUSY.
  - If LATENCY==1, it moves directly to RESP on the next cycle.
- State BUSY:
  - req_ready=0; the counter decrements each cycle.
  - When the counter reaches 0, the RAM access is performed and the block moves to RESP.
  - Stores commit to RAM on the BUSY→RESP edge only. Resetting before that edge leaves RAM unchanged.
- State RESP:
  - resp_valid=1 with rdata/err held stable until resp_valid & resp_ready.
  - On handshake, the block returns to IDLE; req_ready rises the following cycle.
  - No back-to-back acceptance in the same cycle as the response handshake.
- Latency:
  - resp_valid is asserted exactly LATENCY cycles after the request handshake cycle.
  - Minimum request-to-request spacing is LATENCY+1 cycles with resp_ready held high.
- Address decode:
  - Word index = req_addr[log2(DEPTH)+1:2].
  - The address is in range if req_addr < DEPTH*4.
  - The address equal to MMIO_ADDR is the MMIO register.
- Error conditions (resp_err=1, resp_rdata=0, RAM and MMIO unchanged):
  - Address out of range and not MMIO.
  - Load with req_addr[1:0] != 0.
  - Store whose wstrb is not one of 4'b1111 with addr[1:0]=0, 4'b0011/4'b1100 with addr[1:0] in {0,2}, or a single bit set.
  - Store with wstrb=0.
- Stores: bytes with wstrb[i]=1 are written into lane i; other lanes keep their old value. Store response has rdata=0, err=0.
- Loads: return the full 32-bit word; the initiator performs sign/zero extension and lane selection.
- Request inputs are sampled only at handshake; changes while BUSY/RESP are ignored.
- resp_ready held high while in IDLE/BUSY has no effect.

Optional Feature:
- Macro DMEM_MMIO_EN.
- Defined:
  - A store to MMIO_ADDR updates mmio_out per wstrb.
  - A load from MMIO_ADDR returns mmio_out.
  - Neither access raises an error.
- Undefined:
  - MMIO_ADDR decodes like any other address and is therefore out of range, giving resp_err=1.
  - mmio_out is tied to 0 and no register is synthesized.

Test Plan:
- Reset, then store addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF; then load 0x10 -> store response err=0 exactly LATENCY cycles after acceptance; load returns 0xDEADBEEF.
- Byte store 0x11, wdata 0x0000AA00, wstrb 4'b0010 over 0x11223344 at word 0x10; load 0x10 -> 0x1122AA44.
- Load 0x12 (misaligned), load DEPTH*4, store wstrb 4'b0110 -> each gives resp_err=1, rdata=0; memory is unchanged on readback.
- Hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid/rdata stay stable and req_ready=0; they are released one cycle after the handshake.
- Assert rst mid-BUSY during a store to 0x20 (old value 0x5) -> outputs return to reset values immediately; a later load of 0x20 returns 0x5 and no stale response appears.
- With DMEM_MMIO_EN, store 0x0000002A to 0xFFFF0000 -> mmio_out=0x2A and a load returns 0x2A. Without the macro, the same store gives err=1 and mmio_out stays 0.
